// File: rtl/spike_rate_encoder_if.sv
// Request bus for spike_rate_encoder: one magnitude/window pair per valid/ready handshake.
interface spike_rate_encoder_if #(
   parameter int DATA_WIDTH   = 16,
   parameter int WINDOW_WIDTH = 16
);
   logic                    in_valid;
   logic                    in_ready;
   logic [DATA_WIDTH-1:0]   value;
   logic [WINDOW_WIDTH-1:0] window;

   modport master (output in_valid, output value, output window, input in_ready);
   modport slave  (input in_valid, input value, input window, output in_ready);
endinterface

// File: rtl/spike_rate_encoder.sv
// Rate encoder: emits min(value, window) single-cycle spikes spread evenly over
// a window of `window` cycles, using a Bresenham-style accumulator.
module spike_rate_encoder #(
   parameter int DATA_WIDTH   = 16,
   parameter int WINDOW_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rstn,
   spike_rate_encoder_if.slave  req,
   output logic                 spike,
   output logic                 busy,
   output logic                 done
);

   localparam int MAX_WIDTH = (DATA_WIDTH > WINDOW_WIDTH) ? DATA_WIDTH : WINDOW_WIDTH;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                  state_q, state_d;
   logic [WINDOW_WIDTH-1:0] w_r, n_r, n_d;
   logic [WINDOW_WIDTH-1:0] acc_q, acc_d, cnt_q, cnt_d;
   logic [MAX_WIDTH-1:0]    value_ext, window_ext;
   logic [WINDOW_WIDTH:0]   sum;
   logic                    accept, spike_d, done_d;

   assign req.in_ready = (state_q == IDLE);
   assign accept       = req.in_valid && req.in_ready;

   // Clamp is evaluated at the wider of the two widths so no bits of value are lost before comparing.
   assign value_ext  = MAX_WIDTH'(req.value);
   assign window_ext = MAX_WIDTH'(req.window);
   assign n_d        = (value_ext < window_ext) ? value_ext[WINDOW_WIDTH-1:0] : req.window;

   // One extra bit keeps acc + n from wrapping, since both are below 2^WINDOW_WIDTH.
   assign sum = {1'b0, acc_q} + {1'b0, n_r};

   // Next-state, accumulator/counter update and next registered outputs.
   always_comb begin
      state_d = state_q;
      spike_d = 1'b0;
      done_d  = 1'b0;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               acc_d   = '0;
               cnt_d   = '0;
               state_d = (req.window != '0) ? RUN : DRAIN;
            end
         end
         RUN: begin
            if (sum >= {1'b0, w_r}) begin
               spike_d = 1'b1;
               acc_d   = WINDOW_WIDTH'(sum - {1'b0, w_r});
            end else begin
               acc_d   = sum[WINDOW_WIDTH-1:0];
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == w_r - 1'b1) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register and registered outputs; synchronous active-low reset aborts any train.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= IDLE;
         spike   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         spike   <= spike_d;
         busy    <= (state_d != IDLE);
         done    <= done_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end

   // Request capture: window and clamped count are sampled only on the accept edge.
   always_ff @(posedge clk) begin
      if (rstn && accept) begin
         w_r <= req.window;
         n_r <= n_d;
      end
   end

endmodule

// File: doc/spike_rate_encoder.md
# spike_rate_encoder

Converts a multi-bit magnitude into a rate-coded spike train: a value N is emitted as exactly min(N, W) single-cycle spikes spread evenly over a window of W cycles. It is the transmit-side counterpart of the per-neuron spike accumulators. Those count spikes back into a magnitude; this block drives spike inputs into a spiking array or a test harness from numeric data. A valid/ready input handshake loads one magnitude and window per train, and a done pulse marks the end of each train.

## Interface
- DATA_WIDTH, 16, width of magnitude input `value`
- WINDOW_WIDTH, 16, width of window length `window` and internal cycle counter
- clk  input  1  clock, all logic on rising edge
- rstn  input  1  reset, synchronous, active-low
- in_valid  input  1  `value`/`window` valid
- in_ready  output  1  block can accept a request; equals (state == IDLE)
- value  input  DATA_WIDTH  requested spike count N
- window  input  WINDOW_WIDTH  train length W in cycles
- spike  output  1  registered spike output, one-cycle pulses
- busy  output  1  registered; high in RUN and DRAIN
- done  output  1  registered; one-cycle pulse after the last slot of a train

## Operation
- States: IDLE, RUN, DRAIN.
- Accept: a request is accepted on an edge where in_valid && in_ready && rstn.
  - Latch w_r = window.
  - Latch n_r = min(value, window), compared at max(DATA_WIDTH, WINDOW_WIDTH) bits, zero-extended.
  - Clear acc = 0 and cnt = 0.
- IDLE: in_ready = 1, spike = 0, busy = 0.
  - On accept with window != 0: go to RUN.
  - On accept with window == 0: go to DRAIN. The train is zero slots long and no spike is produced.
- RUN: each edge is one slot.
  - sum = acc + n_r, computed at WINDOW_WIDTH+1 bits, so there is no overflow.
  - If sum >= w_r: spike <= 1 and acc <= sum − w_r. Otherwise spike <= 0 and acc <= sum.
  - cnt <= cnt + 1. When cnt == w_r − 1, go to DRAIN.
- DRAIN: on the next edge, spike <= 0, done <= 1, go to IDLE.
- done <= 0 on every edge not leaving DRAIN.
- Invariant: acc < w_r always. The spike count in a train is exactly n_r. The last slot always spikes when n_r > 0.
- Values above W are clamped to W, giving W spikes, every slot high.
- in_valid outside IDLE is ignored. Inputs are not held and are sampled only at accept.
- Reset:
  - Applies on any edge with rstn = 0, including mid-train.
  - Sets state = IDLE, spike = 0, busy = 0, done = 0, acc = 0, cnt = 0.
  - The aborted train produces no done pulse.

## Timing
- Reset values: spike 0, busy 0, done 0, in_ready 1 once rstn is high.
- Edge numbering: E0 is the accept edge, and slot i (i = 1..W) is computed at edge Ei.
- spike for slot i is visible in the cycle after Ei.
- busy is high from the cycle after E0 through the cycle after EW (the DRAIN cycle).
- done is high, with in_ready = 1, in the cycle after E(W+1).
- Total per train: W + 2 cycles from the accept edge to done visible.
- Back-to-back: a request held during the done cycle is accepted at E(W+2). Its first slot appears 1 cycle later.
- Minimum spike-idle gap between trains: 2 cycles, namely the done/IDLE cycle and the accept cycle.
- W = 0: busy is high for 1 cycle (DRAIN), then done. No spike.

## Test plan
- Reset, then value=3, window=4 -> spike pattern 0,1,1,1 over slots 1–4. busy high 5 cycles, done one pulse, in_ready low from cycle after E0 until done cycle.
- value=2, window=5 -> pattern 0,0,1,0,1. Spike count 2. done exactly once.
- value=9, window=4 (clamp) -> 1,1,1,1. value=0, window=4 -> 0,0,0,0 with done. window=0 -> no spike, done 2 cycles after accept.
- Back-to-back: in_valid held high with value=1, window=3 for two requests -> trains 0,0,1 and 0,0,1, second accepted on the done cycle's edge. Requests presented during RUN are ignored and do not alter the train.
- Reset mid-train: value=4, window=8, drop rstn for 1 cycle at slot 3 -> spike, busy and done all 0 next cycle. No done pulse. in_ready = 1 after rstn returns. A new request runs from acc = 0.
- Random sweep with DATA_WIDTH=WINDOW_WIDTH=8, 1000 trains -> per train, spike count == min(value, window). Slot count == window. Gap between consecutive spikes is floor(W/N) or ceil(W/N) when N > 0.
